// File: rtl/fir_pkg.sv
// Shared types, width helpers and default taps for the AXI-Stream FIR.
// Saturating output mode is selected with the FIR_SAT_EN macro in the top.
package fir_pkg;

  // Widest intermediate that sat_fit handles; must be >= the accumulator width.
  localparam int SAT_W = 128;

  // Default taps of the 15-tap low-pass filter, used to preload coefficients.
  localparam int LPF_NTAPS = 15;
  localparam logic [15:0] LPF_TAPS [LPF_NTAPS] = '{
    16'hFC9C, 16'h0000, 16'h05A5, 16'h0000, 16'hF40C, 16'h0000, 16'h282D, 16'h4000,
    16'h282D, 16'h0000, 16'hF40C, 16'h0000, 16'h05A5, 16'h0000, 16'hFC9C
  };

  // Sideband that travels alongside each pipeline stage.
  typedef struct packed {
    logic valid;
    logic last;
  } beat_ctl_t;

  // Width at which the sum of all products can never overflow.
  function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

  // Clamp a signed value into the signed range of out_w bits.
  function automatic logic signed [SAT_W-1:0] sat_fit(
    input  logic signed [SAT_W-1:0] value,
    input  int                      out_w,
    output logic                    clipped
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = SAT_W'(1);
    hi  = (one <<< (out_w - 1)) - one;
    lo  = ~hi;
    clipped = 1'b0;
    if (value > hi) begin
      clipped = 1'b1;
      return hi;
    end
    if (value < lo) begin
      clipped = 1'b1;
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Runtime-loadable coefficient register file; all taps visible in parallel.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int NTAPS  = 15,
  parameter int COEF_W = 16,
  parameter int ADDR_W = $clog2(NTAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr,
  input  logic signed [COEF_W-1:0] data,
  output logic signed [COEF_W-1:0] coef [NTAPS]
);

  // Single write port; addresses beyond the last tap are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: this is a small flop array rather than a RAM, so every entry
      // gets an explicit reset value and the filter starts from all-zero taps.
      for (int k = 0; k < NTAPS; k++) coef[k] <= '0;
    end else if (we && (int'(addr) < NTAPS)) begin
      coef[addr] <= data;
    end
  end

endmodule

// File: rtl/fir_axis_param.sv
// Parametrised N-tap direct-form FIR, AXI-Stream in and out, three stages:
// accept/delay line, multiply, sum/scale/fit. All stages stall together.
// Define FIR_SAT_EN to saturate the output and add m_axis_fir_tuser (clip flag);
// otherwise the output keeps the low OUT_W bits of the scaled sum.
module fir_axis_param
  import fir_pkg::*;
#(
  parameter int NTAPS     = 15,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int OUT_W     = 32,
  parameter int OUT_SHIFT = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [DATA_W-1:0]   s_axis_fir_tdata,
  input  logic                       s_axis_fir_tvalid,
  input  logic                       s_axis_fir_tlast,
  output logic                       s_axis_fir_tready,
  output logic signed [OUT_W-1:0]    m_axis_fir_tdata,
  output logic                       m_axis_fir_tvalid,
  output logic                       m_axis_fir_tlast,
  input  logic                       m_axis_fir_tready,
`ifdef FIR_SAT_EN
  output logic                       m_axis_fir_tuser,
`endif
  input  logic                       cfg_coef_we,
  input  logic [$clog2(NTAPS)-1:0]   cfg_coef_addr,
  input  logic signed [COEF_W-1:0]   cfg_coef_data
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, NTAPS);

  logic signed [COEF_W-1:0] coef [NTAPS];
  logic signed [DATA_W-1:0] taps [NTAPS];
  logic signed [PROD_W-1:0] prod [NTAPS];
  beat_ctl_t                st0;
  beat_ctl_t                st1;
  logic                     ready_en;
  logic                     adv;
  logic                     accept;
  logic signed [ACC_W-1:0]  acc;
  logic signed [OUT_W-1:0]  fit_data;
`ifdef FIR_SAT_EN
  logic                     clip;
`endif

  fir_coef_bank #(
    .NTAPS  (NTAPS),
    .COEF_W (COEF_W),
    .ADDR_W ($clog2(NTAPS))
  ) u_coef_bank (
    .clk   (clk),
    .reset (reset),
    .we    (cfg_coef_we),
    .addr  (cfg_coef_addr),
    .data  (cfg_coef_data),
    .coef  (coef)
  );

  // Keep input ready low until the first edge after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // The whole pipeline moves only when the output register can take a beat.
  assign adv               = !m_axis_fir_tvalid || m_axis_fir_tready;
  assign s_axis_fir_tready = adv && ready_en;
  assign accept            = s_axis_fir_tvalid && s_axis_fir_tready;

  // Stage 0: shift a new sample into the delay line; bubbles leave it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTAPS; k++) taps[k] <= '0;
      st0 <= '0;
    end else if (adv) begin
      // NOTE: non-blocking assignments make every tap read its neighbour's old
      // value, so the loop order does not matter and the line shifts by one.
      st0.valid <= accept;
      st0.last  <= accept && s_axis_fir_tlast;
      if (accept) begin
        taps[0] <= s_axis_fir_tdata;
        for (int k = 1; k < NTAPS; k++) taps[k] <= taps[k-1];
      end
    end
  end

  // Stage 1: full-precision products against the current coefficient bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTAPS; k++) prod[k] <= '0;
      st1 <= '0;
    end else if (adv) begin
      for (int k = 0; k < NTAPS; k++) prod[k] <= taps[k] * coef[k];
      st1 <= st0;
    end
  end

  // Sum all products at a width that cannot overflow.
  always_comb begin
    // NOTE: the accumulator is assigned before the loop on every evaluation,
    // so no path leaves it unassigned and no latch is inferred.
    acc = '0;
    for (int k = 0; k < NTAPS; k++) acc = acc + ACC_W'(prod[k]);
  end

  // Scale the sum and fit it into the output width.
  always_comb begin
`ifdef FIR_SAT_EN
    clip     = 1'b0;
    fit_data = OUT_W'(sat_fit(SAT_W'(acc >>> OUT_SHIFT), OUT_W, clip));
`else
    fit_data = OUT_W'(acc >>> OUT_SHIFT);
`endif
  end

  // Stage 2: output register; held while the downstream stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_axis_fir_tdata  <= '0;
      m_axis_fir_tvalid <= 1'b0;
      m_axis_fir_tlast  <= 1'b0;
`ifdef FIR_SAT_EN
      m_axis_fir_tuser  <= 1'b0;
`endif
    end else if (adv) begin
      m_axis_fir_tdata  <= fit_data;
      m_axis_fir_tvalid <= st1.valid;
      m_axis_fir_tlast  <= st1.last;
`ifdef FIR_SAT_EN
      m_axis_fir_tuser  <= clip && st1.valid;
`endif
    end
  end

endmodule

// File: tb/tb_fir_axis_param.sv
// Scoreboard bench for fir_axis_param (4 taps, 16-bit output so that the
// wrap / saturation behaviour under FIR_SAT_EN is visible).
module tb_fir_axis_param;

  localparam int NT = 4;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int OW = 16;

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
    logic          user;
  } exp_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] s_tdata  = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast  = 1'b0;
  logic          s_tready;
  logic [OW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b1;
`ifdef FIR_SAT_EN
  logic          m_tuser;
`endif
  logic          cfg_we   = 1'b0;
  logic [1:0]    cfg_addr = '0;
  logic [CW-1:0] cfg_data = '0;

  always #5 clk = ~clk;

  fir_axis_param #(
    .NTAPS(NT), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .OUT_SHIFT(0)
  ) dut (
    .clk               (clk),
    .reset             (rst_n),
    .s_axis_fir_tdata  (s_tdata),
    .s_axis_fir_tvalid (s_tvalid),
    .s_axis_fir_tlast  (s_tlast),
    .s_axis_fir_tready (s_tready),
    .m_axis_fir_tdata  (m_tdata),
    .m_axis_fir_tvalid (m_tvalid),
    .m_axis_fir_tlast  (m_tlast),
    .m_axis_fir_tready (m_tready),
`ifdef FIR_SAT_EN
    .m_axis_fir_tuser  (m_tuser),
`endif
    .cfg_coef_we       (cfg_we),
    .cfg_coef_addr     (cfg_addr),
    .cfg_coef_data     (cfg_data)
  );

  exp_t   sb[$];
  exp_t   mon_e;
  int     n_vec = 0;
  int     n_err = 0;
  longint hist [NT];
  longint cm   [NT];
  logic   tl_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic [OW-1:0] d, input logic l, input logic u);
    exp_t e;
    e.data = d;
    e.last = l;
    e.user = u;
    return e;
  endfunction

  // Reference fit of an exact sum into 16 output bits.
  function automatic exp_t fit(input longint s, input logic l);
    exp_t e;
    e.last = l;
    e.user = 1'b0;
`ifdef FIR_SAT_EN
    if (s > 32767) begin
      e.data = 16'h7FFF;
      e.user = 1'b1;
    end else if (s < -32768) begin
      e.data = 16'h8000;
      e.user = 1'b1;
    end else begin
      e.data = s[15:0];
    end
`else
    e.data = s[15:0];
`endif
    return e;
  endfunction

  // Golden convolution over the accepted-sample history.
  function automatic exp_t model_step(input logic signed [DW-1:0] x, input logic l);
    longint s;
    s = 0;
    for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    for (int k = 0; k < NT; k++) s += hist[k] * cm[k];
    return fit(s, l);
  endfunction

  // Monitor: every accepted output beat is compared with the queue head.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got 0x%0h, want no beat at %0t", m_tdata, $time);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", 32'(m_tdata), 32'(mon_e.data));
        check("out_last", 32'(m_tlast), 32'(mon_e.last));
`ifdef FIR_SAT_EN
        check("out_user", 32'(m_tuser), 32'(mon_e.user));
`endif
      end
    end
  end

  task automatic do_reset();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    cfg_we   = 1'b0;
    rst_n    = 1'b0;
    sb.delete();
    for (int k = 0; k < NT; k++) begin
      hist[k] = 0;
      cm[k]   = 0;
    end
    @(negedge clk);
    check("rst_tvalid", 32'(m_tvalid), 0);
    check("rst_tlast",  32'(m_tlast),  0);
    check("rst_tdata",  32'(m_tdata),  0);
    check("rst_tready", 32'(s_tready), 0);
`ifdef FIR_SAT_EN
    check("rst_tuser",  32'(m_tuser),  0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_tready_low", 32'(s_tready), 0);
    @(posedge clk); #1;
    check("rel_tready_rise", 32'(s_tready), 1);
  endtask

  task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
    int c [NT];
    c = '{c0, c1, c2, c3};
    for (int k = 0; k < NT; k++) begin
      cfg_we   = 1'b1;
      cfg_addr = 2'(k);
      cfg_data = 16'(c[k]);
      cm[k]    = longint'($signed(16'(c[k])));
      @(posedge clk); #1;
    end
    cfg_we = 1'b0;
  endtask

  // Offer one beat; the expectation is queued just before the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic l, input exp_t e);
    int budget;
    budget   = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && budget < 200) begin
      budget++;
      @(negedge clk);
    end
    if (!s_tready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: s_tready stayed 0, want 1 at %0t", $time);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      budget++;
      @(negedge clk);
    end
    check("drain_outstanding", 32'(sb.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int imp_exp [5] = '{1, 2, 3, 4, 0};
    int rl_exp  [8] = '{5, 7, 10, 14, 14, 14, 16, 16};

    #2;
    // Impulse response and latency.
    do_reset();
    load_coefs(1, 2, 3, 4);
    send(16'd1, 1'b0, mk(16'(imp_exp[0]), 1'b0, 1'b0));
    @(negedge clk); check("lat_edge_t",  32'(m_tvalid), 0);
    @(negedge clk); check("lat_edge_t1", 32'(m_tvalid), 0);
    @(negedge clk); check("lat_edge_t2", 32'(m_tvalid), 1);
    check("lat_data", 32'(m_tdata), 1);
    @(posedge clk); #1;
    for (int i = 1; i < 5; i++) send(16'd0, 1'b0, mk(16'(imp_exp[i]), 1'b0, 1'b0));
    drain();

    // Backpressure: 5-cycle downstream stall in a continuous stream.
    do_reset();
    load_coefs(1, 2, 3, 4);
    fork
      begin
        for (int i = 1; i <= 12; i++) send(16'(i * 10), 1'b0, model_step(16'(i * 10), 1'b0));
      end
      begin
        logic [OW-1:0] held;
        repeat (6) @(posedge clk);
        #1 m_tready = 1'b0;
        @(negedge clk);
        check("stall_valid", 32'(m_tvalid), 1);
        held = m_tdata;
        for (int i = 0; i < 5; i++) begin
          check("stall_ready", 32'(s_tready), 0);
          if (i > 0) check("stall_hold", 32'(m_tdata), 32'(held));
          if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1 m_tready = 1'b1;
      end
    join
    drain();

    // tlast alignment with random gaps on both sides.
    do_reset();
    load_coefs(1, 2, 3, 4);
    tl_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          send(16'(i * 37 - 100), i == 7, model_step(16'(i * 37 - 100), i == 7));
        end
        tl_done = 1'b1;
      end
      begin
        while (!tl_done) begin
          @(posedge clk); #1;
          m_tready = 1'($urandom_range(0, 1));
        end
        m_tready = 1'b1;
      end
    join
    drain();

    // Output fit: exact sums k*0x3FFF0001 and -0x3FFF8000 against 16 bits.
    do_reset();
    load_coefs(32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF);
    for (int i = 1; i <= 4; i++) begin
`ifdef FIR_SAT_EN
      send(16'h7FFF, 1'b0, mk(16'h7FFF, 1'b0, 1'b1));
`else
      send(16'h7FFF, 1'b0, mk(16'(i), 1'b0, 1'b0));
`endif
    end
    drain();
    do_reset();
    load_coefs(32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF);
`ifdef FIR_SAT_EN
    send(16'h8000, 1'b0, mk(16'h8000, 1'b0, 1'b1));
`else
    send(16'h8000, 1'b0, mk(16'h8000, 1'b0, 1'b0));
`endif
    drain();

    // Coefficient reload on the same edge that accepts sample 6.
    do_reset();
    load_coefs(5, 2, 3, 4);
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin
        cfg_we   = 1'b1;
        cfg_addr = 2'd0;
        cfg_data = 16'd7;
      end
      send(16'd1, 1'b0, mk(16'(rl_exp[i]), 1'b0, 1'b0));
      cfg_we = 1'b0;
    end
    drain();

    // Reset in the middle of a 4-beat burst, then a clean impulse.
    do_reset();
    load_coefs(1, 2, 3, 4);
    for (int i = 0; i < 3; i++) send(16'(i + 5), 1'b0, model_step(16'(i + 5), 1'b0));
    do_reset();
    load_coefs(1, 2, 3, 4);
    send(16'd1, 1'b0, mk(16'(imp_exp[0]), 1'b0, 1'b0));
    for (int i = 1; i < 5; i++) send(16'd0, 1'b0, mk(16'(imp_exp[i]), 1'b0, 1'b0));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_axis_param.md
Name: fir_axis_param

Overview:
- Parametrised N-tap direct-form FIR with AXI-Stream slave input and AXI-Stream master output.
- Successor to the fixed 15-tap LPF, with these additions:
  - runtime-loadable coefficients;
  - full backpressure handling (stall, never drop);
  - tlast aligned to the output data;
  - a configurable output scaling shift.
- Sits between the ADC sample stream and downstream DSP / DMA.

Parameters:
- NTAPS, 15: number of taps, 2..64.
- DATA_W, 16: signed input sample width.
- COEF_W, 16: signed coefficient width.
- OUT_W, 32: signed output width.
- OUT_SHIFT, 0: arithmetic right shift applied to the sum before truncation or saturation.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- s_axis_fir_tdata  in  DATA_W  signed input sample
- s_axis_fir_tvalid  in  1  input valid
- s_axis_fir_tlast  in  1  input end-of-frame marker
- s_axis_fir_tready  out  1  input ready
- m_axis_fir_tdata  out  OUT_W  signed filtered sample
- m_axis_fir_tvalid  out  1  output valid
- m_axis_fir_tlast  out  1  tlast aligned with m_axis_fir_tdata
- m_axis_fir_tready  in  1  downstream ready
- cfg_coef_we  in  1  coefficient write strobe
- cfg_coef_addr  in  $clog2(NTAPS)  tap index
- cfg_coef_data  in  COEF_W  signed coefficient value

Behaviour:
- Reset (async, reset==0):
  - all delay-line samples, coefficients, pipeline valids and m_axis_fir_tdata clear to 0;
  - m_axis_fir_tvalid=0, m_axis_fir_tlast=0;
  - s_axis_fir_tready=0 while reset is held; it rises the first clk after release.
- Pipeline advance: adv = !m_axis_fir_tvalid || m_axis_fir_tready.
  - s_axis_fir_tready = adv (combinational from output state, registered inputs only).
  - When adv=0, every stage holds, including data, valid and tlast.
- Stage 0 (accept, when s_axis_fir_tvalid && s_axis_fir_tready):
  - delay line shifts: x[0]<=tdata, x[k]<=x[k-1];
  - v0<=1, l0<=tlast.
  - If adv=1 with no input: v0<=0 and the delay line holds.
- Stage 1 (multiply): p[k] <= x[k]*c[k], full precision of DATA_W+COEF_W bits. Carries v1 and l1.
- Stage 2 (sum and scale):
  - sum of all p[k] at ACC_W = DATA_W+COEF_W+$clog2(NTAPS), sign-extended, which cannot overflow;
  - then >>> OUT_SHIFT, then fit to OUT_W (see the optional feature);
  - loads m_axis_fir_tdata, m_axis_fir_tvalid=v1, m_axis_fir_tlast=l1.
- Latency: a sample accepted on edge t appears valid after edge t+2, unstalled.
  - Throughput is 1 sample/clk.
  - Bubbles propagate as tvalid=0.
  - Output data is held stable while tvalid=1 and tready=0.
- No warm-up gating: output starts with the first sample, using zero history.
- Coefficients:
  - the write lands on the clk edge where cfg_coef_we=1;
  - it affects a Stage 1 multiply starting from the following edge, regardless of stall;
  - cfg_coef_addr >= NTAPS is ignored.
- Simultaneous coefficient write and stall: the write still completes; any held product is unchanged.
- Reset asserted mid-frame: in-flight samples are discarded and no partial tlast is emitted.

Optional Feature:
- Macro FIR_SAT_EN.
- Defined: the scaled sum saturates to OUT_W signed range, i.e. [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Adds output port m_axis_fir_tuser (1 bit), =1 when the beat was clipped. It is registered with the data and reset to 0.
- Undefined: low OUT_W bits are kept (two's-complement wrap) and there is no tuser port.
- If ACC_W <= OUT_W, both modes sign-extend and are identical.

Decomposition:
- Package fir_pkg:
  - function acc_width(DATA_W, COEF_W, NTAPS);
  - function sat_fit (generic signed saturate);
  - default tap constants for the 15-tap LPF (0xFC9C, 0, 0x05A5, 0, 0xF40C, 0, 0x282D, 0x4000, symmetric), used by testbenches for preload.
- One sub-module, fir_coef_bank: NTAPS x COEF_W register file with async reset and a write port. It exposes all coefficients in parallel.

Test Plan:
- Impulse response: NTAPS=4, coefficients 1,2,3,4, input 1,0,0,0,0 with tready=1 -> outputs 1,2,3,4,0, first valid 2 clks after accept.
- Backpressure: continuous input 10,20,30,...; m_axis_fir_tready low for 5 clks mid-stream -> s_axis_fir_tready=0 during the stall, tdata frozen, no sample dropped or duplicated against a golden model.
- tlast alignment: 8-beat frame with tlast on beat 8, random tvalid/tready gaps -> m_axis_fir_tlast high only on the 8th output beat.
- Saturation: OUT_W=16, OUT_SHIFT=0, all coefficients 0x7FFF, input 0x7FFF ->
  - with FIR_SAT_EN: 0x7FFF and tuser=1;
  - without: the wrapped low 16 bits of the exact sum.
- Coefficient reload: write c[0] = 5 -> 7 mid-stream with constant input 1 -> the sum steps by +2 on the output beat whose Stage 1 multiply begins on the edge after the write, per the Behaviour rule.
- Reset mid-frame: reset low for 1 clk during a 4-beat burst ->
  - all outputs clear;
  - after release, an impulse yields a clean response with no stale taps.
